// File: rtl/yutorina_gpr_wport_arb_pkg.sv
// rtl/yutorina_gpr_wport_arb_pkg.sv - shared GPR widths, write-enable polarity and arbiter defaults
package yutorina_gpr_wport_arb_pkg;

    localparam int WORD_W         = 32;
    localparam int GPR_ADDR_W     = 5;
    localparam int GPR_NUM        = 1 << GPR_ADDR_W;
    localparam int WQ_DEPTH_DEF   = 2;
    localparam int STARVE_LIM_DEF = 8;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;

    localparam gpr_addr_t GPR_ZERO = '0;
    localparam logic      ENABLE_  = 1'b0;
    localparam logic      DISABLE_ = 1'b1;

    typedef struct packed {
        gpr_addr_t addr;
        word_t     data;
    } wq_ent_t;

    // Register 0 is hardwired, so its bit never appears in a mask.
    function automatic logic [GPR_NUM-1:0] gpr_onehot(input gpr_addr_t a, input logic en);
        logic [GPR_NUM-1:0] m;
        m = '0;
        if (en && (a != GPR_ZERO)) begin
            m[a] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/yutorina_gpr_wq.sv
// rtl/yutorina_gpr_wq.sv - FIFO of long-unit GPR writes awaiting a free write-port slot
module yutorina_gpr_wq
    import yutorina_gpr_wport_arb_pkg::*;
#(
    parameter int  DEPTH = WQ_DEPTH_DEF,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  wq_ent_t       i_push_ent,
    input  logic          i_pop,
    output logic [CW-1:0] o_count,
    output wq_ent_t       o_head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wq_ent_t         r_mem [DEPTH];
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_rp;
    logic [CW-1:0]   r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (i_push && !rst) begin
            r_mem[r_wp] <= i_push_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wp <= ptr_inc(r_wp);
            end
            if (i_pop) begin
                r_rp <= ptr_inc(r_rp);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rp];

endmodule

// File: rtl/yutorina_gpr_wport_arb.sv
// rtl/yutorina_gpr_wport_arb.sv - GPR write-port arbiter: pipeline writeback vs queued long-unit writes
module yutorina_gpr_wport_arb
    import yutorina_gpr_wport_arb_pkg::*;
#(
    parameter int WQ_DEPTH   = WQ_DEPTH_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_req,
    input  logic [GPR_ADDR_W-1:0] wb_addr,
    input  logic [WORD_W-1:0]     wb_data,
    input  logic                  lu_req,
    input  logic [GPR_ADDR_W-1:0] lu_addr,
    input  logic [WORD_W-1:0]     lu_data,
    output logic                  lu_rdy,
    input  logic                  sb_set,
    input  logic [GPR_ADDR_W-1:0] sb_set_addr,
    input  logic [GPR_ADDR_W-1:0] chk_addr1,
    input  logic [GPR_ADDR_W-1:0] chk_addr2,
    output logic                  hz1,
    output logic                  hz2,
    output logic                  wb_hold,
    output logic                  gpr_we_,
    output logic [GPR_ADDR_W-1:0] gpr_w_addr,
    output logic [WORD_W-1:0]     gpr_w_data
);

    localparam int CW = $clog2(WQ_DEPTH + 1);
    localparam int AW = $clog2(STARVE_LIM + 1);

    logic [CW-1:0]      w_count;
    wq_ent_t            w_head;
    logic               w_q_nempty;
    logic               w_push;
    logic               w_pop;
    logic               w_sel_vld;
    gpr_addr_t          w_sel_addr;
    word_t              w_sel_data;
    logic [GPR_NUM-1:0] w_set_mask;
    logic [GPR_NUM-1:0] w_clr_mask;

    logic               r_gpr_we_;
    gpr_addr_t          r_gpr_w_addr;
    word_t              r_gpr_w_data;
    logic [GPR_NUM-1:0] r_pending;
    logic [AW-1:0]      r_age;

    yutorina_gpr_wq #(
        .DEPTH(WQ_DEPTH)
    ) u_wq (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_ent ('{addr: lu_addr, data: lu_data}),
        .i_pop      (w_pop),
        .o_count    (w_count),
        .o_head     (w_head)
    );

    assign lu_rdy     = !rst && (w_count < CW'(WQ_DEPTH));
    assign w_push     = lu_req && lu_rdy;
    assign w_q_nempty = (w_count != '0);

    // Writeback has no back-pressure, so it always wins; the queue only drains in gaps.
    assign w_pop      = !rst && !wb_req && w_q_nempty;
    assign w_sel_vld  = wb_req || w_q_nempty;
    assign w_sel_addr = wb_req ? wb_addr : (w_q_nempty ? w_head.addr : GPR_ZERO);
    assign w_sel_data = wb_req ? wb_data : (w_q_nempty ? w_head.data : '0);

    assign w_set_mask = gpr_onehot(sb_set_addr, sb_set);
    assign w_clr_mask = gpr_onehot(w_head.addr, w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpr_we_    <= DISABLE_;
            r_gpr_w_addr <= GPR_ZERO;
            r_gpr_w_data <= '0;
            r_pending    <= '0;
            r_age        <= '0;
        end else begin
            r_gpr_we_    <= (w_sel_vld && (w_sel_addr != GPR_ZERO)) ? ENABLE_ : DISABLE_;
            r_gpr_w_addr <= w_sel_addr;
            r_gpr_w_data <= w_sel_data;
            r_pending    <= (r_pending & ~w_clr_mask) | w_set_mask;
            if (w_pop || !w_q_nempty) begin
                r_age <= '0;
            end else if (r_age < AW'(STARVE_LIM)) begin
                r_age <= r_age + AW'(1);
            end
        end
    end

    assign hz1        = r_pending[chk_addr1];
    assign hz2        = r_pending[chk_addr2];
    assign wb_hold    = (r_age >= AW'(STARVE_LIM));
    assign gpr_we_    = r_gpr_we_;
    assign gpr_w_addr = r_gpr_w_addr;
    assign gpr_w_data = r_gpr_w_data;

endmodule

// File: tb/tb_yutorina_gpr_wport_arb.sv
// tb/tb_yutorina_gpr_wport_arb.sv - directed and randomized checks of the GPR write-port arbiter
module tb_yutorina_gpr_wport_arb;

    localparam int DEPTH = 2;
    localparam int LIM   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_req = 1'b0, lu_req = 1'b0, sb_set = 1'b0;
    logic [4:0]  wb_addr = '0, lu_addr = '0, sb_set_addr = '0, chk_addr1 = '0, chk_addr2 = '0;
    logic [31:0] wb_data = '0, lu_data = '0;
    logic        lu_rdy, hz1, hz2, wb_hold, gpr_we_;
    logic [4:0]  gpr_w_addr;
    logic [31:0] gpr_w_data;

    yutorina_gpr_wport_arb #(.WQ_DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst(rst),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
        .lu_req(lu_req), .lu_addr(lu_addr), .lu_data(lu_data), .lu_rdy(lu_rdy),
        .sb_set(sb_set), .sb_set_addr(sb_set_addr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .hz1(hz1), .hz2(hz2),
        .wb_hold(wb_hold),
        .gpr_we_(gpr_we_), .gpr_w_addr(gpr_w_addr), .gpr_w_data(gpr_w_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    bit          pend[32];
    int          age = 0;
    bit          m_valid = 0;
    bit          m_rst = 0;
    logic        m_we = 1'b1;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    // Reference behaviour for one rising edge, from the pre-edge state and inputs.
    task automatic model_edge();
        int   sz;
        bit   popped;
        ent_t e;
        sz     = mq.size();
        popped = 0;
        m_rst  = rst;
        m_we   = 1'b1;
        if (rst) begin
            mq.delete();
            age = 0;
            foreach (pend[i]) pend[i] = 0;
            m_addr = '0;
            m_data = '0;
        end else begin
            if (wb_req) begin
                m_addr = wb_addr; m_data = wb_data; m_we = (wb_addr == 0);
            end else if (sz > 0) begin
                e = mq.pop_front();
                popped = 1;
                m_addr = e.a; m_data = e.d; m_we = (e.a == 0);
                pend[e.a] = 0;
            end
            if (popped || sz == 0) age = 0;
            else if (age < LIM) age = age + 1;
            if (lu_req && sz < DEPTH) mq.push_back('{a: lu_addr, d: lu_data});
            if (sb_set && sb_set_addr != 0) pend[sb_set_addr] = 1;
        end
        m_valid = 1;
    endtask

    task automatic step(input logic r, input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lr, input logic [4:0] la, input logic [31:0] ld,
                        input logic ss, input logic [4:0] sa, input logic [4:0] c1, input logic [4:0] c2);
        rst = r; wb_req = wr; wb_addr = wa; wb_data = wd;
        lu_req = lr; lu_addr = la; lu_data = ld;
        sb_set = ss; sb_set_addr = sa; chk_addr1 = c1; chk_addr2 = c2;
        #2;
        chk("lu_rdy", {31'd0, lu_rdy}, {31'd0, (!r && mq.size() < DEPTH)});
        if (m_valid) begin
            chk("hz1", {31'd0, hz1}, {31'd0, (c1 != 0) && pend[c1]});
            chk("hz2", {31'd0, hz2}, {31'd0, (c2 != 0) && pend[c2]});
            chk("wb_hold", {31'd0, wb_hold}, {31'd0, age >= LIM});
        end
        @(posedge clk);
        model_edge();
        #1;
        chk("gpr_we_", {31'd0, gpr_we_}, {31'd0, m_we});
        if (!m_we || m_rst) begin
            chk("gpr_w_addr", {27'd0, gpr_w_addr}, {27'd0, m_addr});
            chk("gpr_w_data", gpr_w_data, m_data);
        end
    endtask

    task automatic idle(input logic [4:0] c1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, c1, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_we", {31'd0, gpr_we_}, 32'd1);
        chk("rst_addr", {27'd0, gpr_w_addr}, 32'd0);

        // Minimum long-unit latency
        step(0, 0, 0, 0, 1, 5'd5, 32'hA5A5A5A5, 0, 0, 0, 0);
        idle(0);
        chk("lat_we", {31'd0, gpr_we_}, 32'd0);
        chk("lat_addr", {27'd0, gpr_w_addr}, 32'd5);
        chk("lat_data", gpr_w_data, 32'hA5A5A5A5);
        idle(0);

        // Writeback first, queued write next
        step(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0, 0, 0);
        chk("pri_wb", {27'd0, gpr_w_addr}, 32'd3);
        idle(0);
        chk("pri_lu", {27'd0, gpr_w_addr}, 32'd4);
        chk("pri_lu_we", {31'd0, gpr_we_}, 32'd0);

        // Starvation: fill queue under continuous writeback, then drain
        step(0, 1, 5'd1, 32'h1, 1, 5'd10, 32'h10, 0, 0, 0, 0);
        step(0, 1, 5'd2, 32'h2, 1, 5'd11, 32'h11, 0, 0, 0, 0);
        chk("full_rdy", {31'd0, lu_rdy}, 32'd0);
        for (int i = 0; i < 10; i++) step(0, 1, 5'd6, i, 1, 5'd12, 32'h12, 0, 0, 0, 0);
        chk("starve_hold", {31'd0, wb_hold}, 32'd1);
        idle(0);
        chk("drain0", {27'd0, gpr_w_addr}, 32'd10);
        chk("drain_hold", {31'd0, wb_hold}, 32'd0);
        idle(0);
        chk("drain1", {27'd0, gpr_w_addr}, 32'd11);
        idle(0);

        // Scoreboard set / clear / same-edge set
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
        step(0, 0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 5'd7, 0);
        chk("sb_hz", {31'd0, hz1}, 32'd1);
        idle(5'd7);
        chk("sb_clr", {31'd0, hz1}, 32'd0);
        chk("sb_clr_we", {31'd0, gpr_we_}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
        step(0, 0, 0, 0, 1, 5'd7, 32'h78, 0, 0, 5'd7, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
        chk("sb_setwin", {31'd0, hz1}, 32'd1);
        idle(5'd7);

        // Reset with a full queue and a pending bit
        step(0, 1, 5'd1, 32'h1, 1, 5'd20, 32'h20, 1, 5'd9, 0, 0);
        step(0, 1, 5'd1, 32'h1, 1, 5'd21, 32'h21, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0);
        chk("mid_rst_hz", {31'd0, hz1}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle(5'd9);
            chk("no_stale", {31'd0, gpr_we_}, 32'd1);
        end

        // Writes to register 0 never assert the enable
        step(0, 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 0, 0, 0, 0);
        chk("zero_wb", {31'd0, gpr_we_}, 32'd1);
        idle(0);
        chk("zero_lu", {31'd0, gpr_we_}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/yutorina_gpr_wport_arb.md
YUTORINA_GPR_WPORT_ARB -- requirements
Module: yutorina_gpr_wport_arb

Interface
REQ-001 The block SHALL have parameter WQ_DEPTH, default 2, setting the number of queued long-unit write entries.
REQ-002 The block SHALL have parameter STARVE_LIM, default 8, setting the queue-head age in cycles at which wb_hold asserts.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 wb_req / wb_addr / wb_data  in  1/5/32  pipeline writeback request, register address, data; no ready signal.
REQ-007 lu_req / lu_addr / lu_data  in  1/5/32  long-latency-unit write request, address, data.
REQ-008 lu_rdy  out  1  long-unit transfer accepted this cycle when lu_req and lu_rdy are both high.
REQ-009 sb_set / sb_set_addr  in  1/5  mark a GPR as pending on the long unit.
REQ-010 chk_addr1 / chk_addr2  in  5/5  decoder source addresses to check.
REQ-011 hz1 / hz2  out  1/1  source register pending (hazard).
REQ-012 wb_hold  out  1  request that the pipeline withhold wb_req.
REQ-013 gpr_we_ / gpr_w_addr / gpr_w_data  out  1/5/32  registered GPR write port; gpr_we_ is active-low.

Function
REQ-014 Each cycle, selection SHALL be: wb_req high picks the writeback request; otherwise a non-empty queue pops its head; otherwise nothing is picked.
REQ-015 The selected write SHALL be registered onto gpr_* at the next edge; with no selection, gpr_we_ SHALL be high at that edge.
REQ-016 A selected write to address 0 SHALL be consumed and popped, with gpr_we_ kept high.
REQ-017 lu_rdy SHALL be (count < WQ_DEPTH) while rst is low, SHALL be independent of lu_req, and SHALL be 0 while rst is high.
REQ-018 Every accepted long-unit request SHALL enter the queue; push and pop in the same cycle SHALL leave count unchanged.
REQ-019 Minimum long-unit latency: accepted at cycle N, gpr_we_ low in cycle N+2 if wb_req is low in cycle N+1.
REQ-020 Queue order SHALL be FIFO; no entry SHALL be dropped or duplicated.
REQ-021 Head age counter: cleared on pop or when the queue is empty; otherwise increments each cycle; saturates at STARVE_LIM.
REQ-022 wb_hold SHALL equal (age >= STARVE_LIM), combinationally.
REQ-023 If wb_req is high while wb_hold is high, writeback SHALL still win; the pipeline contract is to honour wb_hold.
REQ-024 Scoreboard pending[31:1]: sb_set with address != 0 SHALL set the bit at the edge; sb_set to address 0 SHALL be ignored.
REQ-025 The pending bit SHALL clear at the edge that registers a queue-sourced write to that address onto gpr_*.
REQ-026 Writeback-sourced writes SHALL NOT clear pending bits.
REQ-027 Same-edge set and clear of one address: set SHALL win.
REQ-028 hz1 = pending[chk_addr1] and hz2 = pending[chk_addr2], combinationally; chk address 0 SHALL give 0.

Reset
REQ-029 While rst is high at an edge: gpr_we_ 1, gpr_w_addr 0, gpr_w_data 0, queue empty, age 0, all pending bits 0.
REQ-030 hz1, hz2 and wb_hold SHALL be 0 from the first cycle after reset.
REQ-031 Reset mid-operation SHALL discard queued entries and in-flight selections; no GPR write SHALL issue in the cycle after reset.

Structure
REQ-032 Word width, GPR address width, GPR_ZERO, and ENABLE_/DISABLE_ SHALL come from the shared gpr/stddef headers.
REQ-033 WQ_DEPTH and STARVE_LIM defaults SHALL be defined as constants in the gpr header.
REQ-034 The queue SHALL be a sub-module yutorina_gpr_wq: parameterised depth, push/pop, count, head data/address.

Verification
REQ-035 Reset, then lu_req addr 5 data 0xA5A5A5A5 at cycle 1, wb_req low -> gpr_we_ low, addr 5, data 0xA5A5A5A5 in cycle 3.
REQ-036 wb_req (addr 3) and lu_req (addr 4) in the same cycle -> addr 3 written first, addr 4 the following cycle.
REQ-037 Two lu pushes with wb_req held high -> lu_rdy 0 after the second push, wb_hold 1 after 8 cycles; drop wb_req -> both entries drain in order and wb_hold falls.
REQ-038 sb_set addr 7 -> hz1 1 for chk_addr1=7; queued lu write to addr 7 popped -> hz1 0 in the cycle gpr_we_ is low; sb_set addr 7 on that same edge -> hz1 stays 1.
REQ-039 Queue full, assert rst one cycle -> queue empty, gpr_we_ 1, pending 0, no stale write afterwards; a write to addr 0 never drives gpr_we_ low.
